bru_q: RTL and testbench
========================

Name: bru_q

Overview:
- Parametrised branch resolution unit with a DEPTH-entry in-order result queue, which replaces the single-entry output buffer of the current branch unit.
- Sits between the branch reservation station and the writeback/ROB/fetch-redirect paths.
- Resolves BRANCH and JUMP uops in the accept cycle and buffers the results in a queue.
- Discards results whose epoch is stale, so that no redirect or writeback is issued for a squashed path.
- Keeps wrapping performance counters for resolved branches and mispredicts.

Parameters:
- DEPTH, 4, result queue entries; power of two, minimum 2.
- EPOCH_W, 2, epoch tag width; must match rs_uop_t.epoch.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cur_epoch  in  EPOCH_W  current front-end epoch.
- req_valid  in  1  uop offered.
- req_ready  out  1  uop accepted when req_valid && req_ready.
- req_uop  in  rs_uop_t  bundle fields: pc, imm, uop_class, branch_type, uses_rs1, uses_rd, pred_taken, pred_target; plus rob_idx, prd_new, epoch.
- rs1_val  in  32  source operand 1.
- rs2_val  in  32  source operand 2.
- wb_valid  out  1  head entry is live.
- wb_ready  in  1  writeback consumer ready.
- wb_uses_rd  out  1  head writes rd.
- wb_epoch  out  EPOCH_W  head epoch.
- wb_rob_idx  out  ROB_W  head ROB index.
- wb_prd_new  out  PHYS_W  head destination physical register.
- wb_data  out  32  head pc+4 (return address).
- wb_pc  out  32  head instruction PC.
- br_valid  out  1  live head retires this cycle.
- act_taken  out  1  head resolved direction.
- target_pc  out  32  head resolved target.
- mispredict  out  1  head mispredicted.
- redirect_valid  out  1  br_valid && mispredict.
- redirect_pc  out  32  correct next PC.
- occupancy  out  $clog2(DEPTH)+1  number of queued entries.
- br_cnt  out  CNT_W  count of br_valid pulses.
- mispred_cnt  out  CNT_W  count of redirect_valid pulses.

Behaviour:
- Resolve (combinational, from current inputs):
  - BRANCH: BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned; target = pc+imm.
  - JUMP: always taken. If uses_rs1, target = (rs1+imm) & ~1; otherwise target = pc+imm.
  - Any other class: not taken; target = pc+4.
  - mispredict = (taken != pred_taken) || (taken && target != pred_target).
  - redirect_pc = taken ? target : pc+4.
  - All arithmetic is 32-bit modulo.
- Enqueue: on the req handshake, push one entry holding the resolved result and metadata to the tail.
- Head liveness: head is live iff queue is non-empty and head.epoch == cur_epoch. cur_epoch is sampled combinationally every cycle.
- Dequeue:
  - Live head: pops when wb_ready. In that cycle br_valid=1, and redirect_valid=1 if the head mispredicted.
  - Stale head: pops unconditionally with wb_valid=0, br_valid=0, redirect_valid=0, and no counter update.
  - At most one pop per cycle.
- wb_valid = head live, regardless of uses_rd, because the ROB needs completion for every uop. Dequeue of a live head always waits for wb_ready.
- req_ready = (occupancy < DEPTH) || pop this cycle. Simultaneous push and pop when full is legal and keeps occupancy unchanged.
- Latency: an uop accepted in cycle N is presented at cycle N+1 if the queue was empty. Sustained throughput is 1 uop/cycle.
- Holding the head: all wb_* and branch outputs reflect the head entry and stay stable while wb_valid && !wb_ready.
- Empty queue: all outputs are driven from the head slot, but the valid signals (wb_valid, br_valid, redirect_valid) are 0.
- Pointers: read and write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full/empty is decided by the MSB compare.
- Counters increment on br_valid and redirect_valid respectively and wrap at 2^CNT_W.
- Reset (rst sampled at posedge):
  - Queue empties; pointers, occupancy and counters go to 0.
  - All valid outputs are 0 in the cycle after rst asserts.
  - Data outputs read 0, because the storage registers are reset.
  - A request presented during reset is not accepted: req_ready=0 while rst=1.

Decomposition:
- Package defines.svh additions:
  - bru_entry_t struct {pc, uses_rd, epoch, rob_idx, prd_new, taken, target, mispred, redirect_pc}.
  - BRU_DEPTH_DEFAULT constant.
- Reused from the package: existing rs_uop_t, BR_* and UOP_* enums.
- Sub-module bru_res_fifo:
  - Parametrised DEPTH FIFO of bru_entry_t.
  - Provides push/pop/full/empty/count.
  - Has no knowledge of epochs.
- bru_q holds the resolve logic, liveness gating and counters.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle wb_valid=1, act_taken=1, target_pc=0x120, redirect_valid=1 with wb_ready=1, redirect_pc=0x120, mispred_cnt=1.
- JALR, rs1=0x1003, imm=4, pc=0x200, pred_target=0x1006, pred_taken=1 -> target 0x1006, mispredict=0, wb_data=0x204.
- Hold wb_ready=0; push 4 uops, then a 5th -> req_ready=0 on the 5th, occupancy=4. Raise wb_ready with req_valid held -> one push and one pop per cycle, occupancy stays 4, FIFO order preserved.
- Enqueue 2 uops with epoch=1, then switch cur_epoch=2 -> both pop over 2 cycles with wb_valid=0 and br_valid=0; br_cnt unchanged.
- BLTU rs1=0xFFFF_FFFF, rs2=1 -> not taken; BLT with the same operands -> taken (signed compare).
- Assert rst with 3 entries queued -> next cycle occupancy=0, wb_valid=0, br_cnt=0, req_ready=0 while rst=1.

Source files
------------

// File: rtl/bru_q_pkg.sv
// Shared types for the branch resolution unit: uop bundle, class/branch enums,
// and the resolved-result entry held in the bru_q result queue.
package bru_q_pkg;

  localparam int unsigned BRU_DEPTH_DEFAULT = 4;
  localparam int unsigned BRU_EPOCH_W       = 2;
  localparam int unsigned ROB_W             = 6;
  localparam int unsigned PHYS_W            = 7;

  typedef enum logic [1:0] {
    UOP_ALU    = 2'd0,
    UOP_MEM    = 2'd1,
    UOP_BRANCH = 2'd2,
    UOP_JUMP   = 2'd3
  } uop_class_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd4,
    BR_GE  = 3'd5,
    BR_LTU = 3'd6,
    BR_GEU = 3'd7
  } br_type_e;

  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            imm;
    uop_class_e             uop_class;
    br_type_e               branch_type;
    logic                   uses_rs1;
    logic                   uses_rd;
    logic                   pred_taken;
    logic [31:0]            pred_target;
    logic [ROB_W-1:0]       rob_idx;
    logic [PHYS_W-1:0]      prd_new;
    logic [BRU_EPOCH_W-1:0] epoch;
  } rs_uop_t;

  typedef struct packed {
    logic [31:0]            pc;
    logic                   uses_rd;
    logic [BRU_EPOCH_W-1:0] epoch;
    logic [ROB_W-1:0]       rob_idx;
    logic [PHYS_W-1:0]      prd_new;
    logic                   taken;
    logic [31:0]            target;
    logic                   mispred;
    logic [31:0]            redirect_pc;
  } bru_entry_t;

endpackage

// File: rtl/bru_q_if.sv
// Request and writeback/branch bundle between the reservation station,
// the branch resolution unit and its downstream consumers.
interface bru_q_if;
  import bru_q_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  rs_uop_t                req_uop;
  logic [31:0]            rs1_val;
  logic [31:0]            rs2_val;

  logic                   wb_valid;
  logic                   wb_ready;
  logic                   wb_uses_rd;
  logic [BRU_EPOCH_W-1:0] wb_epoch;
  logic [ROB_W-1:0]       wb_rob_idx;
  logic [PHYS_W-1:0]      wb_prd_new;
  logic [31:0]            wb_data;
  logic [31:0]            wb_pc;

  logic                   br_valid;
  logic                   act_taken;
  logic [31:0]            target_pc;
  logic                   mispredict;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;

  modport master (
    output req_valid, req_uop, rs1_val, rs2_val, wb_ready,
    input  req_ready, wb_valid, wb_uses_rd, wb_epoch, wb_rob_idx, wb_prd_new,
           wb_data, wb_pc, br_valid, act_taken, target_pc, mispredict,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_uop, rs1_val, rs2_val, wb_ready,
    output req_ready, wb_valid, wb_uses_rd, wb_epoch, wb_rob_idx, wb_prd_new,
           wb_data, wb_pc, br_valid, act_taken, target_pc, mispredict,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/bru_res_fifo.sv
// In-order FIFO of resolved branch entries. Pointers carry one extra wrap
// bit so full and empty are distinguished by the MSB compare. Epoch-agnostic.
module bru_res_fifo
  import bru_q_pkg::*;
#(
  parameter int unsigned DEPTH = BRU_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  bru_entry_t             push_data,
  input  logic                   pop,
  output bru_entry_t             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = 1;

  logic [IDX_W:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0] rd_ptr_q, rd_ptr_d;
  bru_entry_t     mem_q [DEPTH];
  bru_entry_t     mem_d [DEPTH];

  // Next-state for pointers and storage; a write into the slot being read
  // on a full push+pop is safe because the read is taken before the edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
      wr_ptr_d                   = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer and storage registers, all cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Status and head read-out.
  always_comb begin
    pop_data = mem_q[rd_ptr_q[IDX_W-1:0]];
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
               (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
  end

endmodule

// File: rtl/bru_q.sv
// Branch resolution unit: resolves BRANCH/JUMP uops in the accept cycle,
// queues results in order, drops stale-epoch heads silently, and keeps
// wrapping counters of retired branches and mispredicts.
module bru_q
  import bru_q_pkg::*;
#(
  parameter int unsigned DEPTH   = BRU_DEPTH_DEFAULT,
  parameter int unsigned EPOCH_W = BRU_EPOCH_W,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EPOCH_W-1:0]     cur_epoch,
  bru_q_if.slave                 bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       br_cnt,
  output logic [CNT_W-1:0]       mispred_cnt
);

  rs_uop_t     uop;
  bru_entry_t  res;
  bru_entry_t  head;
  logic [31:0] a;
  logic [31:0] b;
  logic        cond;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        live;

  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // Resolve the offered uop: direction, target, mispredict and next PC.
  always_comb begin
    uop  = bus.req_uop;
    a    = bus.rs1_val;
    b    = bus.rs2_val;
    cond = 1'b0;
    case (uop.branch_type)
      BR_EQ:   cond = (a == b);
      BR_NE:   cond = (a != b);
      BR_LT:   cond = ($signed(a) <  $signed(b));
      BR_GE:   cond = ($signed(a) >= $signed(b));
      BR_LTU:  cond = (a <  b);
      BR_GEU:  cond = (a >= b);
      default: cond = 1'b0;
    endcase

    res         = '0;
    res.pc      = uop.pc;
    res.uses_rd = uop.uses_rd;
    res.epoch   = uop.epoch;
    res.rob_idx = uop.rob_idx;
    res.prd_new = uop.prd_new;
    res.taken   = 1'b0;
    res.target  = uop.pc + 32'd4;
    case (uop.uop_class)
      UOP_BRANCH: begin
        res.taken  = cond;
        res.target = uop.pc + uop.imm;
      end
      UOP_JUMP: begin
        res.taken  = 1'b1;
        res.target = uop.uses_rs1 ? ((a + uop.imm) & ~32'd1) : (uop.pc + uop.imm);
      end
      default: ;
    endcase
    res.mispred     = (res.taken != uop.pred_taken) ||
                      (res.taken && (res.target != uop.pred_target));
    res.redirect_pc = res.taken ? res.target : (uop.pc + 32'd4);
  end

  // Handshake: a stale head pops unconditionally, a live one waits for wb_ready.
  always_comb begin
    live          = !empty && (head.epoch == cur_epoch);
    pop           = !empty && (!live || bus.wb_ready);
    bus.req_ready = !rst && (!full || pop);
    push          = bus.req_valid && bus.req_ready;
  end

  bru_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (res),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (occupancy)
  );

  // Head presentation; data always reflects the head slot, valids are gated.
  always_comb begin
    bus.wb_valid       = live;
    bus.wb_uses_rd     = head.uses_rd;
    bus.wb_epoch       = head.epoch;
    bus.wb_rob_idx     = head.rob_idx;
    bus.wb_prd_new     = head.prd_new;
    bus.wb_data        = head.pc + 32'd4;
    bus.wb_pc          = head.pc;
    bus.br_valid       = live && bus.wb_ready;
    bus.act_taken      = head.taken;
    bus.target_pc      = head.target;
    bus.mispredict     = head.mispred;
    bus.redirect_valid = bus.br_valid && head.mispred;
    bus.redirect_pc    = head.redirect_pc;
  end

  // Counter next-state; wraps naturally at 2^CNT_W.
  always_comb begin
    br_cnt_d      = br_cnt_q + {{(CNT_W-1){1'b0}}, bus.br_valid};
    mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, bus.redirect_valid};
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bru_q.sv
// Bench for bru_q: table of branch vectors with hand-derived results, plus
// sequences for full-queue streaming, stale-epoch drop and reset.
module tb_bru_q;
  import bru_q_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cur_epoch;
  logic [2:0]  occupancy;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_br = 0;
  int exp_mis = 0;

  bru_q_if bus ();

  bru_q #(
    .DEPTH   (4),
    .EPOCH_W (2),
    .CNT_W   (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cur_epoch   (cur_epoch),
    .bus         (bus),
    .occupancy   (occupancy),
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  rob;
    logic [6:0]  prd;
    logic        uses_rd;
    logic [1:0]  epoch;
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic [31:0] redir;
  } exp_t;

  typedef struct {
    string       name;
    uop_class_e  cls;
    br_type_e    bt;
    logic        use1;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic        pt;
    logic [31:0] ptgt;
    logic        tk;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] redir;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_uop(input rs_uop_t u, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    bit acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_uop   = u;
    bus.rs1_val   = a;
    bus.rs2_val   = b;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        sbq.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: got no req_ready expected accept");
    end
  endtask

  task automatic mk_alu(input logic [31:0] pc, input int idx, output rs_uop_t u, output exp_t e);
    u             = '0;
    u.pc          = pc;
    u.uop_class   = UOP_ALU;
    u.uses_rd     = 1'b1;
    u.rob_idx     = 6'(idx);
    u.prd_new     = 7'(idx + 40);
    u.epoch       = cur_epoch;
    e.pc          = pc;
    e.rob         = 6'(idx);
    e.prd         = 7'(idx + 40);
    e.uses_rd     = 1'b1;
    e.epoch       = cur_epoch;
    e.taken       = 1'b0;
    e.target      = pc + 32'd4;
    e.mis         = 1'b0;
    e.redir       = pc + 32'd4;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    rs_uop_t u;
    exp_t    e;
    u             = '0;
    u.pc          = v.pc;
    u.imm         = v.imm;
    u.uop_class   = v.cls;
    u.branch_type = v.bt;
    u.uses_rs1    = v.use1;
    u.uses_rd     = (v.cls == UOP_JUMP);
    u.pred_taken  = v.pt;
    u.pred_target = v.ptgt;
    u.rob_idx     = 6'(idx);
    u.prd_new     = 7'(idx + 10);
    u.epoch       = cur_epoch;
    e.pc          = v.pc;
    e.rob         = 6'(idx);
    e.prd         = 7'(idx + 10);
    e.uses_rd     = (v.cls == UOP_JUMP);
    e.epoch       = cur_epoch;
    e.taken       = v.tk;
    e.target      = v.tgt;
    e.mis         = v.mis;
    e.redir       = v.redir;
    push_uop(u, v.a, v.b, e);
    chk({v.name, "_latency_wb_valid"}, {31'd0, bus.wb_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: compares the presented head with the oldest live
  // expectation; stale expectations are discarded as the DUT drops them.
  always @(negedge clk) begin
    if (!rst) begin
      while (sbq.size() > 0 && sbq[0].epoch != cur_epoch) void'(sbq.pop_front());
      if (bus.wb_valid) begin
        if (sbq.size() == 0) begin
          chk("wb_valid_unexpected", {31'd0, bus.wb_valid}, 32'd0);
        end else begin
          chk("wb_pc", bus.wb_pc, sbq[0].pc);
          chk("wb_data", bus.wb_data, sbq[0].pc + 32'd4);
          chk("wb_meta", {16'd0, bus.wb_uses_rd, bus.wb_epoch, bus.wb_rob_idx, bus.wb_prd_new},
              {16'd0, sbq[0].uses_rd, sbq[0].epoch, sbq[0].rob, sbq[0].prd});
          chk("act_taken", {31'd0, bus.act_taken}, {31'd0, sbq[0].taken});
          chk("target_pc", bus.target_pc, sbq[0].target);
          chk("mispredict", {31'd0, bus.mispredict}, {31'd0, sbq[0].mis});
          chk("redirect_pc", bus.redirect_pc, sbq[0].redir);
          chk("br_valid", {31'd0, bus.br_valid}, {31'd0, bus.wb_ready});
          chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, bus.wb_ready && sbq[0].mis});
          if (bus.wb_ready) begin
            exp_br++;
            if (sbq[0].mis) exp_mis++;
            void'(sbq.pop_front());
          end
        end
      end else begin
        chk("br_valid_idle", {31'd0, bus.br_valid}, 32'd0);
        chk("redirect_valid_idle", {31'd0, bus.redirect_valid}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rs_uop_t u;
    exp_t    e;

    tbl[0] = '{"beq",  UOP_BRANCH, BR_EQ,  1'b0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0,
               1'b1, 32'h120, 1'b1, 32'h120};
    tbl[1] = '{"jalr", UOP_JUMP,   BR_EQ,  1'b1, 32'h200, 32'h4, 32'h1003, 32'h0, 1'b1, 32'h1006,
               1'b1, 32'h1006, 1'b0, 32'h1006};
    tbl[2] = '{"bltu", UOP_BRANCH, BR_LTU, 1'b0, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0,
               1'b0, 32'h340, 1'b0, 32'h304};
    tbl[3] = '{"blt",  UOP_BRANCH, BR_LT,  1'b0, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0,
               1'b1, 32'h340, 1'b1, 32'h340};
    tbl[4] = '{"bne",  UOP_BRANCH, BR_NE,  1'b0, 32'h400, 32'hFFFF_FFF8, 32'd7, 32'd7, 1'b1, 32'h3F8,
               1'b0, 32'h3F8, 1'b1, 32'h404};
    tbl[5] = '{"bge",  UOP_BRANCH, BR_GE,  1'b0, 32'h500, 32'h10, 32'h8000_0000, 32'd0, 1'b1, 32'h510,
               1'b0, 32'h510, 1'b1, 32'h504};
    tbl[6] = '{"bgeu", UOP_BRANCH, BR_GEU, 1'b0, 32'h500, 32'h10, 32'h8000_0000, 32'd0, 1'b1, 32'h510,
               1'b1, 32'h510, 1'b0, 32'h510};
    tbl[7] = '{"jal",  UOP_JUMP,   BR_EQ,  1'b0, 32'h600, 32'h100, 32'h0, 32'h0, 1'b1, 32'h704,
               1'b1, 32'h700, 1'b1, 32'h700};
    tbl[8] = '{"alu",  UOP_ALU,    BR_EQ,  1'b0, 32'h700, 32'h10, 32'd3, 32'd3, 1'b0, 32'h0,
               1'b0, 32'h704, 1'b0, 32'h704};
    tbl[9] = '{"wrap", UOP_BRANCH, BR_EQ,  1'b0, 32'hFFFF_FFF0, 32'h20, 32'd1, 32'd1, 1'b1, 32'h10,
               1'b1, 32'h10, 1'b0, 32'h10};

    bus.req_valid = 1'b0;
    bus.req_uop   = '0;
    bus.rs1_val   = '0;
    bus.rs2_val   = '0;
    bus.wb_ready  = 1'b0;
    cur_epoch     = 2'd1;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_br_cnt", br_cnt, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors, one at a time with the consumer ready
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], i);
      if (i == 0) begin
        chk("beq_br_cnt", br_cnt, 32'd1);
        chk("beq_mispred_cnt", mispred_cnt, 32'd1);
      end
    end
    chk("tbl_br_cnt", br_cnt, 32'(exp_br));
    chk("tbl_mispred_cnt", mispred_cnt, 32'(exp_mis));
    chk("tbl_br_cnt_abs", br_cnt, 32'd10);
    chk("tbl_mispred_cnt_abs", mispred_cnt, 32'd5);

    // Fill with the consumer stalled, then stream with push+pop when full
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mk_alu(32'h1000 + 32'(i * 16), 20 + i, u, e);
      push_uop(u, 32'd0, 32'd0, e);
    end
    chk("full_occupancy", {29'd0, occupancy}, 32'd4);
    mk_alu(32'h1040, 24, u, e);
    bus.req_valid = 1'b1;
    bus.req_uop   = u;
    @(negedge clk);
    chk("full_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("full_hold_occupancy", {29'd0, occupancy}, 32'd4);
    @(posedge clk); #1;
    bus.wb_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      mk_alu(32'h1000 + 32'(i * 16), 20 + i, u, e);
      push_uop(u, 32'd0, 32'd0, e);
      chk("stream_occupancy", {29'd0, occupancy}, 32'd4);
    end
    for (int k = 0; k < 20 && occupancy != 3'd0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_occupancy", {29'd0, occupancy}, 32'd0);
    chk("drain_sb_empty", 32'(sbq.size()), 32'd0);

    // Stale epoch: two queued entries dropped without writeback
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mk_alu(32'h2000 + 32'(i * 4), 30 + i, u, e);
      push_uop(u, 32'd0, 32'd0, e);
    end
    chk("stale_pre_occupancy", {29'd0, occupancy}, 32'd2);
    cur_epoch = 2'd2;
    @(negedge clk);
    chk("stale_wb_valid0", {31'd0, bus.wb_valid}, 32'd0);
    @(posedge clk); #1;
    chk("stale_occupancy1", {29'd0, occupancy}, 32'd1);
    @(negedge clk);
    chk("stale_wb_valid1", {31'd0, bus.wb_valid}, 32'd0);
    @(posedge clk); #1;
    chk("stale_occupancy0", {29'd0, occupancy}, 32'd0);
    chk("stale_br_cnt", br_cnt, 32'(exp_br));
    chk("stale_br_cnt_abs", br_cnt, 32'd18);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      mk_alu(32'h3000 + 32'(i * 4), 40 + i, u, e);
      push_uop(u, 32'd0, 32'd0, e);
    end
    chk("rst3_pre_occupancy", {29'd0, occupancy}, 32'd3);
    rst = 1'b1;
    mk_alu(32'h3100, 50, u, e);
    bus.req_valid = 1'b1;
    bus.req_uop   = u;
    @(negedge clk);
    chk("rst3_req_ready_a", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rst3_occupancy", {29'd0, occupancy}, 32'd0);
    chk("rst3_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst3_br_cnt", br_cnt, 32'd0);
    chk("rst3_mispred_cnt", mispred_cnt, 32'd0);
    chk("rst3_wb_pc", bus.wb_pc, 32'd0);
    chk("rst3_target_pc", bus.target_pc, 32'd0);
    @(negedge clk);
    chk("rst3_req_ready_b", {31'd0, bus.req_ready}, 32'd0);
    sbq.delete();
    exp_br  = 0;
    exp_mis = 0;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.wb_ready  = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset
    run_vec(tbl[0], 60);
    chk("post_rst_br_cnt", br_cnt, 32'd1);
    chk("post_rst_mispred_cnt", mispred_cnt, 32'd1);
    chk("post_rst_sb_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
